// File: rtl/vit_csr_pkg.sv
// Shared constants and FSM state types for the ViT CSR AXI-Lite slave.
package vit_csr_pkg;
  localparam int LOG2_REG_NUM = 5;
  localparam int REG_NUM      = 2 ** LOG2_REG_NUM;
  localparam int PERF_BASE    = 27;
  localparam int PERF_NUM     = 4;
  localparam int CTRL_IDX     = 0;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/vit_csr_axil_slave_if.sv
// AXI4-Lite bus bundle between the CPU GP port and the ViT CSR slave.
interface vit_csr_axil_slave_if #(
  parameter int ADDR_W = 7
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awvalid, awaddr, awprot, wdata, wstrb, wvalid, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awvalid, awaddr, awprot, wdata, wstrb, wvalid, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vit_csr_axil_slave.sv
// AXI4-Lite CSR file for the ViT accelerator: start pulse, busy/done status, perf counters.
// Define CSR_WSTRB_EN to honour per-byte write strobes; otherwise all 32 bits are written.
module vit_csr_axil_slave
  import vit_csr_pkg::*;
#(
  parameter int LOG2_REG_NUM = vit_csr_pkg::LOG2_REG_NUM,
  parameter int ADDR_W       = LOG2_REG_NUM + 2,
  parameter int PERF_BASE    = vit_csr_pkg::PERF_BASE,
  localparam int REG_NUM     = 2 ** LOG2_REG_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  vit_csr_axil_slave_if.slave    s_axi,
  output logic [REG_NUM*32-1:0]  csr_regs,
  output logic                   start_o,
  input  logic                   done_i,
  input  logic [4*32-1:0]        perf_cnt_i
);

  logic [31:0] regs [REG_NUM];

  wr_state_t w_state;
  rd_state_t r_state;

  logic                    awready_q, wready_q, bvalid_q;
  logic                    arready_q, rvalid_q;
  logic [31:0]             rdata_q;
  logic                    aw_held, w_held;
  logic [LOG2_REG_NUM-1:0] aw_idx;
  logic [31:0]             wdata_q;
`ifdef CSR_WSTRB_EN
  logic [3:0]              wstrb_q;
`endif
  logic                    busy, done;

  logic                    start_fire, wr_store;
  logic [31:0]             wr_mask;
  logic [LOG2_REG_NUM-1:0] rd_idx;
  logic [1:0]              perf_sel;
  logic [31:0]             rd_val;
  logic                    unused_bits;

  function automatic logic is_perf(input logic [LOG2_REG_NUM-1:0] idx);
    return (int'(idx) >= PERF_BASE) && (int'(idx) < PERF_BASE + PERF_NUM);
  endfunction

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

`ifdef CSR_WSTRB_EN
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
`else
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         s_axi.wstrb};
`endif

  always_comb begin
`ifdef CSR_WSTRB_EN
    wr_mask    = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    start_fire = (int'(aw_idx) == CTRL_IDX) && wdata_q[0] && wstrb_q[0];
`else
    wr_mask    = '1;
    start_fire = (int'(aw_idx) == CTRL_IDX) && wdata_q[0];
`endif
    wr_store   = (int'(aw_idx) != CTRL_IDX) && !is_perf(aw_idx);
  end

  // AW and W are captured independently; the commit happens one edge after both are held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx    <= '0;
      wdata_q   <= '0;
`ifdef CSR_WSTRB_EN
      wstrb_q   <= '0;
`endif
      start_o   <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      start_o <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            if (wr_store) regs[aw_idx] <= (regs[aw_idx] & ~wr_mask) | (wdata_q & wr_mask);
            start_o  <= start_fire;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            w_state  <= W_RESP;
          end else begin
            if (s_axi.awvalid && awready_q) begin
              aw_idx    <= s_axi.awaddr[ADDR_W-1:2];
              aw_held   <= 1'b1;
              awready_q <= 1'b0;
            end else begin
              awready_q <= !aw_held;
            end
            if (s_axi.wvalid && wready_q) begin
              wdata_q  <= s_axi.wdata;
`ifdef CSR_WSTRB_EN
              wstrb_q  <= s_axi.wstrb;
`endif
              w_held   <= 1'b1;
              wready_q <= 1'b0;
            end else begin
              wready_q <= !w_held;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // A start in the same cycle as done_i wins, so a back-to-back relaunch is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start_o) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if (done_i) begin
      busy <= 1'b0;
      done <= 1'b1;
    end
  end

  always_comb begin
    rd_idx   = s_axi.araddr[ADDR_W-1:2];
    perf_sel = 2'(rd_idx - LOG2_REG_NUM'(PERF_BASE));
    rd_val   = regs[rd_idx];
    if (int'(rd_idx) == CTRL_IDX) begin
      rd_val            = '0;
      rd_val[STAT_BUSY] = busy;
      rd_val[STAT_DONE] = done;
    end else if (is_perf(rd_idx)) begin
      rd_val = perf_cnt_i[{perf_sel, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.arvalid && arready_q) begin
            rdata_q   <= rd_val;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Control and perf slots have no storage, so they appear as zero on the datapath bus.
  for (genvar i = 0; i < REG_NUM; i++) begin : g_bus
    if (i == CTRL_IDX || (i >= PERF_BASE && i < PERF_BASE + PERF_NUM)) begin : g_zero
      assign csr_regs[32*i +: 32] = '0;
    end else begin : g_reg
      assign csr_regs[32*i +: 32] = regs[i];
    end
  end

endmodule

// File: tb/tb_vit_csr_axil_slave.sv
// Self-checking bench for vit_csr_axil_slave: directed scenarios plus randomized traffic vs a model.
`timescale 1ns/1ps
module tb_vit_csr_axil_slave;
  import vit_csr_pkg::*;

  localparam int AW = LOG2_REG_NUM + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_o;
  logic                  done_i;
  logic [REG_NUM*32-1:0] csr_regs;
  logic [127:0]          perf_cnt_i;

  vit_csr_axil_slave_if #(.ADDR_W(AW)) bus ();

  vit_csr_axil_slave dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi      (bus),
    .csr_regs   (csr_regs),
    .start_o    (start_o),
    .done_i     (done_i),
    .perf_cnt_i (perf_cnt_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  logic [31:0] mregs [REG_NUM];
  logic        m_busy, m_done;
  int          m_starts = 0;

  always @(negedge clk) if (start_o === 1'b1) start_cnt++;

  function automatic bit is_perf_idx(input int idx);
    return idx >= PERF_BASE && idx < PERF_BASE + 4;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
`ifdef CSR_WSTRB_EN
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
    return 32'hFFFF_FFFF;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < REG_NUM; i++) mregs[i] = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = strb_mask(s);
    if (idx == 0) begin
      if (d[0] && m[0]) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_starts++;
      end
    end else if (!is_perf_idx(idx)) begin
      mregs[idx] = (mregs[idx] & ~m) | (d & m);
    end
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 0) return {30'b0, m_done, m_busy};
    if (is_perf_idx(idx)) return perf_cnt_i[32*(idx-PERF_BASE) +: 32];
    return mregs[idx];
  endfunction

  task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int hold, input bit done_at_start,
                           output bit start_seen);
    int n;
    bit aw_done, w_done, aw_fire, w_fire, bad;
    start_seen = 1'b0;
    bus.awaddr = AW'(idx * 4 + int'($urandom_range(0, 3)));
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.awvalid = (order != 2);
    bus.wvalid  = (order != 1);
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(posedge clk); #1; n++;
      if (aw_fire) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  bus.wvalid  = 1'b0; end
      if (order == 1 && aw_done && !w_done) bus.wvalid = 1'b1;
      if (order == 2 && w_done && !aw_done) bus.awvalid = 1'b1;
    end
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("[TB] FAIL write_accept idx=%0d: got aw=%0b w=%0b, expected both accepted", idx, aw_done, w_done);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.bvalid !== 1'b1 || n != 1) begin
      errors++;
      $display("[TB] FAIL b_latency idx=%0d: got bvalid after %0d cycles, expected 1", idx, n);
      if (bus.bvalid !== 1'b1) return;
    end
    start_seen = start_o;
    if (done_at_start) done_i = 1'b1;
    model_write(idx, data, strb);
    bus.bready = 1'b0;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      bus.awvalid = 1'b1;
      @(posedge clk); #1;
      done_i = 1'b0;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b100) bad = 1;
    end
    bus.awvalid = 1'b0;
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++;
        $display("[TB] FAIL b_hold idx=%0d: got bvalid=%b awready=%b, expected 1/0 throughout", idx, bus.bvalid, bus.awready);
      end
    end
    checks++;
    if (bus.bresp !== RESP_OKAY) begin
      errors++;
      $display("[TB] FAIL bresp idx=%0d: got %b, expected 00", idx, bus.bresp);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b_release idx=%0d: got bvalid=%b, expected 0", idx, bus.bvalid);
    end
  endtask

  task automatic axi_read(input int idx, input int hold, output logic [31:0] data);
    int n;
    bit bad;
    data = 'x;
    bus.araddr  = AW'(idx * 4 + int'($urandom_range(0, 3)));
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ar_timeout idx=%0d: got arready=%b, expected 1", idx, bus.arready);
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL r_latency idx=%0d: got rvalid=%b one cycle after AR, expected 1", idx, bus.rvalid);
    end
    data = bus.rdata;
    bus.rready = 1'b0;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      bus.arvalid = 1'b1;
      @(posedge clk); #1;
      if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== data) bad = 1;
    end
    bus.arvalid = 1'b0;
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++;
        $display("[TB] FAIL r_hold idx=%0d: got rvalid=%b arready=%b rdata=%h, expected 1/0/%h stable", idx, bus.rvalid, bus.arready, bus.rdata, data);
      end
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rresp !== RESP_OKAY) begin
      errors++;
      $display("[TB] FAIL r_release idx=%0d: got rvalid=%b rresp=%b, expected 0/00", idx, bus.rvalid, bus.rresp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    done_i = 1'b0;
    perf_cnt_i = '0;
    bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0;
    bus.rready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, start_o} !== 6'b0 || bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy/vld=%b rdata=%h, expected all 0",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, start_o}, bus.rdata);
    end
    checks++;
    if (csr_regs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got nonzero csr_regs %h, expected 0", csr_regs[255:0]);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL idle_ready: got %b, expected 111", {bus.awready, bus.wready, bus.arready});
    end
    axi_read(0, 0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h, expected 00000000", d);
    end
  endtask

  task automatic test_basic_write_read();
    logic [31:0] d;
    bit s;
    axi_write(5, 32'h0800_0000, 4'hF, 1, 0, 0, s);
    axi_read(5, 0, d);
    checks++;
    if (d !== 32'h0800_0000) begin
      errors++;
      $display("[TB] FAIL basic_read: got %h, expected 08000000", d);
    end
    checks++;
    if (csr_regs[191:160] !== 32'h0800_0000) begin
      errors++;
      $display("[TB] FAIL basic_bus: got %h, expected 08000000", csr_regs[191:160]);
    end
    axi_write(6, 32'hDEAD_BEEF, 4'hF, 2, 0, 0, s);
    axi_read(6, 0, d);
    checks++;
    if (d !== model_read(6)) begin
      errors++;
      $display("[TB] FAIL w_first_read: got %h, expected %h", d, model_read(6));
    end
  endtask

  task automatic test_start_done();
    logic [31:0] d;
    bit s;
    int c0;
    c0 = start_cnt;
    axi_write(0, 32'h1, 4'hF, 0, 0, 0, s);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s !== 1'b1 || start_cnt - c0 != 1) begin
      errors++;
      $display("[TB] FAIL start_pulse: got seen=%b cycles=%0d, expected 1/1", s, start_cnt - c0);
    end
    axi_read(0, 0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("[TB] FAIL status_busy: got %h, expected 00000001", d);
    end
    @(posedge clk); #1; done_i = 1'b1;
    @(posedge clk); #1; done_i = 1'b0;
    m_busy = 1'b0; m_done = 1'b1;
    axi_read(0, 0, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("[TB] FAIL status_done: got %h, expected 00000002", d);
    end
    @(posedge clk); #1; done_i = 1'b1;
    @(posedge clk); #1; done_i = 1'b0;
    axi_read(0, 0, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("[TB] FAIL done_idle: got %h, expected 00000002", d);
    end
    c0 = start_cnt;
    axi_write(0, 32'hFFFF_FFFE, 4'hF, 0, 0, 0, s);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s !== 1'b0 || start_cnt != c0) begin
      errors++;
      $display("[TB] FAIL no_start_bit0: got seen=%b cycles=%0d, expected 0/0", s, start_cnt - c0);
    end
    axi_write(0, 32'h1, 4'hF, 0, 0, 1, s);
    axi_read(0, 0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("[TB] FAIL start_wins: got %h, expected 00000001", d);
    end
  endtask

  task automatic test_perf();
    logic [31:0] d;
    bit s;
    perf_cnt_i = {32'hA5A5_0003, 32'h0000_1111, 32'd1234, 32'h0F0F_0000};
    axi_write(28, 32'd99, 4'hF, 0, 0, 0, s);
    axi_read(28, 0, d);
    checks++;
    if (d !== 32'd1234) begin
      errors++;
      $display("[TB] FAIL perf28: got %0d, expected 1234", d);
    end
    axi_read(30, 0, d);
    checks++;
    if (d !== 32'hA5A5_0003) begin
      errors++;
      $display("[TB] FAIL perf30: got %h, expected a5a50003", d);
    end
    checks++;
    if (csr_regs[28*32 +: 32] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL perf_bus: got %h, expected 00000000", csr_regs[28*32 +: 32]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    bit s;
    axi_write(9, 32'h5A5A_1234, 4'hF, 0, 5, 0, s);
    axi_read(9, 5, d);
    checks++;
    if (d !== 32'h5A5A_1234) begin
      errors++;
      $display("[TB] FAIL backpressure_read: got %h, expected 5a5a1234", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bit s;
    axi_write(12, 32'h1357_9BDF, 4'hF, 0, 0, 0, s);
    @(posedge clk); #1;
    bus.awaddr = AW'(12 * 4); bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = AW'(12 * 4); bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1 || bus.rdata !== 32'h1357_9BDF) begin
      errors++;
      $display("[TB] FAIL collision: got rvalid=%b bvalid=%b rdata=%h, expected 1/1/13579bdf", bus.rvalid, bus.bvalid, bus.rdata);
    end
    model_write(12, 32'hCAFE_F00D, 4'hF);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(12, 0, d);
    checks++;
    if (d !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL collision_after: got %h, expected cafef00d", d);
    end
  endtask

`ifdef CSR_WSTRB_EN
  task automatic test_wstrb();
    logic [31:0] d;
    bit s;
    int c0;
    axi_write(7, 32'h1122_3344, 4'hF, 0, 0, 0, s);
    axi_write(7, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, s);
    axi_read(7, 0, d);
    checks++;
    if (d !== 32'h11BB_33DD) begin
      errors++;
      $display("[TB] FAIL wstrb_merge: got %h, expected 11bb33dd", d);
    end
    c0 = start_cnt;
    axi_write(0, 32'h1, 4'b1110, 0, 0, 0, s);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s !== 1'b0 || start_cnt != c0) begin
      errors++;
      $display("[TB] FAIL wstrb_start: got seen=%b cycles=%0d, expected 0/0", s, start_cnt - c0);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] d, e;
    logic [3:0]  st;
    int idx, op;
    bit s, exp_s;
    for (int it = 0; it < 60; it++) begin
      perf_cnt_i = {$urandom, $urandom, $urandom, $urandom};
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, REG_NUM - 1);
      if (op < 5) begin
        d  = $urandom;
        st = 4'($urandom);
        exp_s = (idx == 0) && d[0] && strb_mask(st)[0];
        axi_write(idx, d, st, $urandom_range(0, 2), $urandom_range(0, 2), 0, s);
        checks++;
        if (s !== exp_s) begin
          errors++;
          $display("[TB] FAIL rand_start it=%0d idx=%0d: got %b, expected %b", it, idx, s, exp_s);
        end
      end else if (op < 9) begin
        axi_read(idx, $urandom_range(0, 2), d);
        e = model_read(idx);
        checks++;
        if (d !== e) begin
          errors++;
          $display("[TB] FAIL rand_read it=%0d idx=%0d: got %h, expected %h", it, idx, d, e);
        end
      end else begin
        @(posedge clk); #1; done_i = 1'b1;
        @(posedge clk); #1; done_i = 1'b0;
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    bit s;
    int n;
    bus.awaddr = AW'(3 * 4); bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, start_o} !== 6'b0 || bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got rdy/vld=%b rdata=%h, expected all 0",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, start_o}, bus.rdata);
    end
    checks++;
    if (csr_regs !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_regs: got nonzero csr_regs, expected 0");
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    axi_write(3, 32'h0BAD_F00D, 4'hF, 0, 0, 0, s);
    axi_read(3, 0, d);
    checks++;
    if (d !== 32'h0BAD_F00D) begin
      errors++;
      $display("[TB] FAIL midreset_recover: got %h, expected 0badf00d", d);
    end
  endtask

  task automatic test_final_state();
    logic [REG_NUM*32-1:0] exp_bus;
    for (int i = 0; i < REG_NUM; i++)
      exp_bus[32*i +: 32] = (i == 0 || is_perf_idx(i)) ? 32'h0 : mregs[i];
    checks++;
    if (csr_regs !== exp_bus) begin
      errors++;
      $display("[TB] FAIL csr_bus: got %h, expected %h (low 256 bits)", csr_regs[255:0], exp_bus[255:0]);
    end
    checks++;
    if (start_cnt != m_starts) begin
      errors++;
      $display("[TB] FAIL start_count: got %0d pulses, expected %0d", start_cnt, m_starts);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic_write_read();
    test_start_done();
    test_perf();
    test_backpressure();
    test_collision();
`ifdef CSR_WSTRB_EN
    test_wstrb();
`endif
    test_random();
    test_final_state();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vit_csr_axil_slave.md
Name: vit_csr_axil_slave

Overview:
- AXI4-Lite responder that terminates the CPU's GP control port.
- Holds the accelerator's CSR file: REG_NUM x 32-bit registers, flattened onto one output bus for the datapath.
- Generates the run start pulse, tracks busy/done, and exposes read-only performance counters at indices 27-30.
- Sits between the CPU's AXI-Lite master and the DMA/FSM control inputs of the ViT wrapper.

Parameters:
- LOG2_REG_NUM, 5, log2 of register count; REG_NUM = 2**LOG2_REG_NUM.
- ADDR_W, LOG2_REG_NUM+2, byte address width.
- PERF_BASE, 27, index of the first of four read-only performance registers.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_AWADDR  in  ADDR_W  byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_ARADDR  in  ADDR_W  byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake.
- csr_regs  out  REG_NUM*32  register file; reg i at bits [32i+:32].
- start_o  out  1  one-cycle run start pulse.
- done_i  in  1  single-cycle run-complete pulse from the FSM.
- perf_cnt_i  in  4*32  performance counters; counter k is read at index PERF_BASE+k.

Behaviour:
- Reset (asynchronous, active-high):
  - All READY/VALID outputs = 0; RDATA = 0; start_o = 0.
  - All registers = 0; busy = 0; done = 0.
  - Asserting rst mid-transaction aborts it with no response; the master must reissue.
- Register index is addr[ADDR_W-1:2]; addr[1:0] is ignored. Every index is in range and every response is OKAY.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY = 1 until AW is captured; WREADY = 1 until W is captured. AW and W are accepted independently, in either order or the same cycle.
  - Once both are held, commit on the next edge and go to W_RESP.
  - W_RESP: BVALID = 1, held until BREADY. Return to W_IDLE on the edge where BVALID & BREADY.
  - Throughput: at most one write per 2 cycles.
- Commit rules:
  - Index 0: no storage. WDATA[0] = 1 fires start_o for exactly one cycle, on the cycle after commit.
  - Indices PERF_BASE..PERF_BASE+3: write is ignored; the B response is still issued.
  - All other indices: reg is fully replaced by WDATA.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY = 1. On AR handshake, RDATA is registered and the FSM goes to R_DATA. Latency AR handshake to RVALID = 1 cycle.
  - R_DATA: ARREADY = 0; RVALID and RDATA held stable until RREADY.
- Read map:
  - Index 0 returns {30'b0, done, busy}.
  - PERF_BASE+k returns perf_cnt_i[32k+:32], sampled at the AR handshake edge.
  - All other indices return the stored value.
- Read and write are independent. If an AR handshake coincides with a write commit edge to the same index, read returns the pre-write value.
- busy/done:
  - start sets busy = 1 and clears done.
  - done_i clears busy and sets done (sticky).
  - start and done_i on the same cycle: start wins (busy = 1, done = 0).
  - done_i while idle: done = 1, busy stays 0.
- csr_regs is driven directly from storage; reg 0 and the perf slots read as 0 on this bus.

Optional Feature:
- Macro CSR_WSTRB_EN.
  - Defined: each byte lane b of a stored register updates only when WSTRB[b] = 1. For index 0, the start pulse requires WSTRB[0] = 1.
  - Undefined: WSTRB is ignored and all 32 bits are written.

Decomposition:
- Shared package vit_csr_pkg holds: LOG2_REG_NUM, REG_NUM, PERF_BASE, the CTRL index (0), status bit positions (BUSY = 0, DONE = 1), and RESP_OKAY = 2'b00.
- No sub-module: both channel FSMs stay in this block; the register file is an inline array.

Test Plan:
- Write 32'h0800_0000 to index 5 (AW one cycle before W), then read index 5 -> BVALID after both are captured, BRESP = 0. RDATA = 32'h0800_0000, RVALID 1 cycle after the AR handshake. csr_regs[191:160] = 32'h0800_0000.
- Write 1 to index 0 -> start_o high for exactly one cycle and read of index 0 = 1. Pulse done_i -> read of index 0 = 2.
- Drive perf_cnt_i[1] = 1234 and write 99 to index 28 -> B response OKAY, read of index 28 = 1234.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable, no new AW/AR is accepted, and the transfer completes on release.
- Assert rst mid-write with AW captured but W not -> all outputs = 0 immediately. The next full write completes normally.
- With CSR_WSTRB_EN defined: write 32'hAABBCCDD with WSTRB = 4'b0101 over 32'h11223344 -> read returns 32'h11BB33DD.
